// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction memory
// and registers the returned word with its PC into the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_BYTES = 120,
    parameter logic [31:0] NOP_INSN  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] inst_addr,
    input  logic [31:0] instruction_in,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    state_t      state_r;
    state_t      state_next_s;
    logic [63:0] pc_r;
    logic [63:0] pc_next_s;
    logic [63:0] pc_seq_s;
    logic        target_misaligned_s;
    logic        target_in_range_s;
    logic        fetch_ok_s;
    logic        halted_r;
    logic        fault_r;
    logic [63:0] if_id_pc_r;
    logic [31:0] if_id_instruction_r;
    logic        if_id_valid_r;
    logic [31:0] fetch_count_r;

    assign pc_seq_s            = pc_r + 64'd4;
    assign target_misaligned_s = (branch_target[1:0] != 2'b00);
    assign target_in_range_s   = (branch_target < MEM_LIMIT);
    // Only a RUN-state PC inside the memory yields a real instruction.
    assign fetch_ok_s          = (state_r == ST_RUN) && (pc_r < MEM_LIMIT);

    assign inst_addr         = pc_r;
    assign if_id_pc          = if_id_pc_r;
    assign if_id_instruction = if_id_instruction_r;
    assign if_id_valid       = if_id_valid_r;
    assign halted            = halted_r;
    assign fetch_fault       = fault_r;
    assign fetch_count       = fetch_count_r;

    // Next PC and fetch state: redirect beats stall, which beats sequential advance.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        case (state_r)
            ST_RUN, ST_HALT: begin
                if (branch_taken) begin
                    if (target_misaligned_s) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        pc_next_s    = branch_target;
                        state_next_s = target_in_range_s ? ST_RUN : ST_HALT;
                    end
                end else if (stall) begin
                    state_next_s = state_r;
                end else if (state_r == ST_RUN) begin
                    pc_next_s    = pc_seq_s;
                    state_next_s = (pc_seq_s < MEM_LIMIT) ? ST_RUN : ST_HALT;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_FAULT: begin
                state_next_s = ST_FAULT;
            end
            default: begin
                // An illegal encoding is treated as a fault so fetch stops safely.
                state_next_s = ST_FAULT;
            end
        endcase
    end

    // PC, state and the status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_RUN;
            pc_r     <= RESET_PC;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            halted_r <= (state_next_s != ST_RUN);
            fault_r  <= fault_r | (state_next_s == ST_FAULT);
        end
    end

    // IF/ID pipeline register and delivered-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_pc_r          <= 64'h0;
            if_id_instruction_r <= NOP_INSN;
            if_id_valid_r       <= 1'b0;
            fetch_count_r       <= 32'd0;
        end else if (flush) begin
            if_id_pc_r          <= 64'h0;
            if_id_instruction_r <= NOP_INSN;
            if_id_valid_r       <= 1'b0;
        end else if (stall) begin
            if_id_pc_r          <= if_id_pc_r;
            if_id_instruction_r <= if_id_instruction_r;
            if_id_valid_r       <= if_id_valid_r;
        end else if (fetch_ok_s) begin
            if_id_pc_r          <= pc_r;
            if_id_instruction_r <= instruction_in;
            if_id_valid_r       <= 1'b1;
            fetch_count_r       <= fetch_count_r + 32'd1;
        end else begin
            if_id_pc_r          <= 64'h0;
            if_id_instruction_r <= NOP_INSN;
            if_id_valid_r       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural fetch model checked every cycle,
// plus hand-computed expectations along the scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [63:0] inst_addr;
    logic [31:0] instruction_in;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        halted;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    localparam logic [31:0] NOP = 32'h00000013;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .inst_addr(inst_addr), .instruction_in(instruction_in),
        .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
        .if_id_valid(if_id_valid), .halted(halted),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a < 64'd120) mem_word = 32'h00000AB3 | {a[15:0], 16'h0000};
        else             mem_word = 32'hDEADBEEF;
    endfunction

    always_comb instruction_in = mem_word(inst_addr);

    typedef struct packed {
        logic [63:0] pc;
        logic        stopped;
        logic        fault;
        logic [63:0] q_pc;
        logic [31:0] q_ins;
        logic        q_valid;
        logic [31:0] count;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t s, input logic rst, input logic st,
                                          input logic fl, input logic br, input logic [63:0] tgt);
        model_t n = s;
        if (rst) begin
            n = '{pc: 64'h0, stopped: 1'b0, fault: 1'b0, q_pc: 64'h0, q_ins: NOP,
                  q_valid: 1'b0, count: 32'd0};
            return n;
        end
        if (fl || (!st && (s.stopped || s.pc >= 64'd120))) begin
            n.q_pc = 64'h0; n.q_ins = NOP; n.q_valid = 1'b0;
        end else if (!st) begin
            n.q_pc = s.pc; n.q_ins = mem_word(s.pc); n.q_valid = 1'b1;
            n.count = s.count + 32'd1;
        end
        if (br && !s.fault) begin
            if (tgt % 64'd4 != 64'd0) begin
                n.fault = 1'b1; n.stopped = 1'b1;
            end else begin
                n.pc = tgt; n.stopped = (tgt >= 64'd120);
            end
        end else if (!st && !s.stopped) begin
            n.pc = s.pc + 64'd4;
            n.stopped = (n.pc >= 64'd120);
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, reset, stall, flush, branch_taken, branch_target);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("m.inst_addr", inst_addr, m.pc);
            check("m.if_id_pc", if_id_pc, m.q_pc);
            check("m.if_id_instruction", {32'h0, if_id_instruction}, {32'h0, m.q_ins});
            check("m.if_id_valid", {63'h0, if_id_valid}, {63'h0, m.q_valid});
            check("m.halted", {63'h0, halted}, {63'h0, m.stopped});
            check("m.fetch_fault", {63'h0, fetch_fault}, {63'h0, m.fault});
            check("m.fetch_count", {32'h0, fetch_count}, {32'h0, m.count});
        end
    end

    task automatic drive(input logic r, input logic s, input logic f, input logic b,
                         input logic [63:0] t);
        reset = r; stall = s; flush = f; branch_taken = b; branch_target = t;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(2);
        check_en = 1'b1;
        check("rst.inst_addr", inst_addr, 64'h0);
        check("rst.if_id_pc", if_id_pc, 64'h0);
        check("rst.instruction", {32'h0, if_id_instruction}, 64'h13);
        check("rst.valid", {63'h0, if_id_valid}, 64'h0);
        check("rst.halted", {63'h0, halted}, 64'h0);
        check("rst.count", {32'h0, fetch_count}, 64'h0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1);
        check("run.if_id_pc", if_id_pc, 64'h0);
        check("run.instruction", {32'h0, if_id_instruction}, 64'h00000AB3);
        check("run.valid", {63'h0, if_id_valid}, 64'h1);
        check("run.count", {32'h0, fetch_count}, 64'd1);
        check("run.addr4", inst_addr, 64'h4);
        cyc(1);
        check("run.addr8", inst_addr, 64'h8);
        cyc(1);

        // redirect with flush at pc 0x0C
        drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h50);
        cyc(1);
        check("br.bubble_valid", {63'h0, if_id_valid}, 64'h0);
        check("br.addr", inst_addr, 64'h50);
        check("br.count", {32'h0, fetch_count}, 64'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1);
        check("br.if_id_pc", if_id_pc, 64'h50);
        check("br.instruction", {32'h0, if_id_instruction}, 64'h00500AB3);
        check("br.count2", {32'h0, fetch_count}, 64'd4);

        // stall for three cycles at pc 0x20
        drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h1C);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        cyc(3);
        check("stall.addr", inst_addr, 64'h20);
        check("stall.if_id_pc", if_id_pc, 64'h1C);
        check("stall.count", {32'h0, fetch_count}, 64'd5);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1);
        check("stall.release", inst_addr, 64'h24);
        check("stall.count2", {32'h0, fetch_count}, 64'd6);

        // stall and flush together at pc 0x10
        drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h10);
        cyc(1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc(1);
        check("sf.addr", inst_addr, 64'h10);
        check("sf.valid", {63'h0, if_id_valid}, 64'h0);
        check("sf.instruction", {32'h0, if_id_instruction}, 64'h13);

        // redirect overrides stall
        drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h30);
        cyc(1);
        check("brst.addr", inst_addr, 64'h30);
        check("brst.count", {32'h0, fetch_count}, 64'd6);

        // aligned redirect beyond memory halts
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h100);
        cyc(1);
        check("oor.halted", {63'h0, halted}, 64'h1);
        check("oor.addr", inst_addr, 64'h100);
        check("oor.count", {32'h0, fetch_count}, 64'd7);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(2);
        check("oor.valid", {63'h0, if_id_valid}, 64'h0);

        // fresh run to the end of memory
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(30);
        check("end.if_id_pc", if_id_pc, 64'h74);
        check("end.valid", {63'h0, if_id_valid}, 64'h1);
        check("end.halted", {63'h0, halted}, 64'h1);
        check("end.count", {32'h0, fetch_count}, 64'd30);
        cyc(2);
        check("end.valid2", {63'h0, if_id_valid}, 64'h0);
        check("end.count2", {32'h0, fetch_count}, 64'd30);
        check("end.addr", inst_addr, 64'h78);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
        cyc(1);
        check("resume.halted", {63'h0, halted}, 64'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(2);
        check("resume.count", {32'h0, fetch_count}, 64'd32);

        // misaligned redirect is a sticky fault
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h52);
        cyc(1);
        check("fault.flag", {63'h0, fetch_fault}, 64'h1);
        check("fault.halted", {63'h0, halted}, 64'h1);
        check("fault.addr", inst_addr, 64'h8);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
        cyc(1);
        check("fault.ignored", inst_addr, 64'h8);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(2);
        check("fault.sticky", {63'h0, fetch_fault}, 64'h1);

        // reset beats pending stall, flush and redirect
        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h40);
        cyc(1);
        check("rst2.fault", {63'h0, fetch_fault}, 64'h0);
        check("rst2.addr", inst_addr, 64'h0);
        check("rst2.count", {32'h0, fetch_count}, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1);
        check("rst2.count2", {32'h0, fetch_count}, 64'd1);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 64-bit RISC-V core. Owns the program counter, drives the byte address into the combinational instruction memory, and registers the returned 32-bit word with its PC into the IF/ID pipeline register. Handles stall, branch redirect, flush and end-of-program halt, and counts delivered instructions. Sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- MEM_BYTES, 120, instruction memory size in bytes; the valid fetch range is PC < MEM_BYTES
- NOP_INSN, 32'h00000013, bubble word (addi x0,x0,0)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold the PC and IF/ID register (load-use or memory stall)
- flush  in  1  replace the IF/ID contents with a bubble
- branch_taken  in  1  redirect request from execute
- branch_target  in  64  redirect byte address
- inst_addr  out  64  byte address to instruction memory; combinational copy of the PC
- instruction_in  in  32  word returned by instruction memory, same cycle as inst_addr
- if_id_pc  out  64  PC of the registered instruction
- if_id_instruction  out  32  registered instruction word
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch is stopped (PC out of range or fault)
- fetch_fault  out  1  sticky; set on a misaligned redirect target
- fetch_count  out  32  number of valid instructions loaded into IF/ID; wraps at 2^32

## Operation
- FSM states:
  - RUN: normal fetching.
  - HALT: PC is out of range; no fetching.
  - FAULT: misaligned redirect; terminal until reset.
- inst_addr = pc at all times. An out-of-range address is still driven, but the returned word is ignored.
- PC update priority: reset > branch_taken > stall > pc+4.
  - branch_taken overrides stall, so a redirect is never lost.
  - The PC does not advance in HALT or FAULT, except on a redirect out of HALT.
- Redirect handling:
  - branch_target[1:0] != 0: go to FAULT and set fetch_fault. The PC is left unchanged.
  - Aligned target >= MEM_BYTES: PC loads the target and the FSM goes to HALT.
  - Aligned target < MEM_BYTES: PC loads the target and the FSM goes to RUN. This is valid from HALT too.
- RUN → HALT when the next sequential PC >= MEM_BYTES.
- IF/ID update priority: reset > flush > stall > load.
  - flush: valid=0, instruction=NOP_INSN, pc=0. flush beats stall.
  - stall without flush: hold all IF/ID fields and fetch_count.
  - load in RUN with pc < MEM_BYTES: pc, instruction_in and valid=1 are registered, and fetch_count increments.
  - load in HALT or FAULT: bubble, valid=0.
- A cycle with branch_taken=1 loads the word at the current PC normally. Execute must assert flush in the same cycle to squash it.
- halted = (state != RUN). All address arithmetic is 64-bit unsigned; pc+4 wraps modulo 2^64.

## Timing
- Reset values:
  - pc = RESET_PC, state = RUN
  - if_id_pc = 0, if_id_instruction = NOP_INSN, if_id_valid = 0
  - halted = 0, fetch_fault = 0, fetch_count = 0
- The instruction at PC p appears on if_id_* one edge after inst_addr = p (1-cycle latency).
- Redirect: branch_taken sampled at edge N puts the target on inst_addr after edge N. Its word reaches IF/ID after edge N+1.
- Reset mid-operation overrides everything at the next edge, including a pending stall, flush or redirect.
- Simultaneous stall and flush: the PC holds and IF/ID becomes a bubble.

## Test plan
- Reset then run free: inst_addr steps 0, 4, 8. After the first edge, if_id_pc = 0, if_id_instruction = 32'h00000AB3, valid = 1, fetch_count = 1.
- branch_taken with target 0x50, driven while pc = 0x0C and flush is asserted: the IF/ID bubble has valid = 0. The next cycles show inst_addr = 0x50, then if_id_pc = 0x50, and fetch_count is not incremented for the bubble.
- stall held for 3 cycles at pc = 0x20: inst_addr stays 0x20, the IF/ID fields and fetch_count are frozen, and pc = 0x24 appears after release.
- stall and flush together at pc = 0x10: pc stays 0x10 and if_id_valid = 0 with instruction 32'h00000013.
- Sequential run to pc = 0x74 (MEM_BYTES 120): the last valid if_id_pc = 0x74 and halted rises. Afterwards if_id_valid = 0 and fetch_count = 30. A later redirect to 0x0 resumes RUN.
- Redirect to 0x52: fetch_fault = 1 and halted = 1, sticky until reset. A following aligned redirect to 0x0 is ignored. Reset clears all state.
